mem_stage: RTL and testbench

Pipeline stage downstream of the execute stage in the 16-bit core. It registers execute-stage results, holds the architectural V/Z/N flag register, and resolves conditional branches against it, issuing a one-cycle flush and redirect target. It also runs the data-memory access handshake with wait states, stalls upstream while a load or store is outstanding, and presents the writeback result.

---
 rtl/mem_pkg.sv | 18 +
 rtl/branch_cond.sv | 27 ++
 rtl/mem_stage.sv | 126 ++++++++++++
 tb/tb_mem_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the memory/writeback pipeline stage.
package mem_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_OV  = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    typedef enum logic {RUN, WAIT} state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluation against a V/Z/N flag set.
module branch_cond
    import mem_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       v,
    input  logic       z,
    input  logic       n,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE:  taken = ~z;
            COND_EQ:  taken = z;
            COND_GT:  taken = ~z & ~n;
            COND_LT:  taken = n;
            COND_GE:  taken = z | ~n;
            COND_LE:  taken = n | z;
            COND_OV:  taken = v;
            COND_UNC: taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: registers execute results, owns the flag register, resolves
// branches, and runs the data-memory handshake with wait states.
module mem_stage
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_v,
    input  logic              ex_z,
    input  logic              ex_n,
    input  logic              ex_set_flags,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic              ex_branch,
    input  logic [2:0]        ex_cond,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_dst,
    input  logic              ex_reg_we,
    output logic              stall,
    output logic              flush,
    output logic [DATA_W-1:0] pc_redirect,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_re,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_rdy,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_dst,
    output logic [DATA_W-1:0] wb_data
);

    state_t             state;
    logic               flagV;
    logic               flagZ;
    logic               flagN;
    logic [REG_W-1:0]   pendDst;
    logic               pendWe;
    logic               condTaken;

    // Evaluated against the pre-update flags, so a branch never sees its own flag write.
    branch_cond uCond (
        .cond  (ex_cond),
        .v     (flagV),
        .z     (flagZ),
        .n     (flagN),
        .taken (condTaken)
    );

    assign stall = (state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            flagV       <= 1'b0;
            flagZ       <= 1'b0;
            flagN       <= 1'b0;
            pendDst     <= '0;
            pendWe      <= 1'b0;
            flush       <= 1'b0;
            pc_redirect <= '0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            dm_re       <= 1'b0;
            dm_we       <= 1'b0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_dst      <= '0;
            wb_data     <= '0;
        end else begin
            wb_valid <= 1'b0;
            flush    <= 1'b0;
            case (state)
                RUN: begin
                    if (ex_valid) begin
                        if (ex_branch) begin
                            flush    <= condTaken;
                            if (condTaken) pc_redirect <= ex_branch_target;
                            wb_valid <= 1'b1;
                            wb_we    <= 1'b0;
                            wb_dst   <= ex_dst;
                            wb_data  <= ex_alu_result;
                        end else begin
                            if (ex_set_flags) begin
                                flagV <= ex_v;
                                flagZ <= ex_z;
                                flagN <= ex_n;
                            end
                            if (ex_mem_rd || ex_mem_wr) begin
                                dm_addr  <= ex_alu_result;
                                dm_wdata <= ex_store_data;
                                dm_re    <= ex_mem_rd;
                                dm_we    <= ~ex_mem_rd;
                                pendDst  <= ex_dst;
                                pendWe   <= ex_reg_we;
                                state    <= WAIT;
                            end else begin
                                wb_valid <= 1'b1;
                                wb_we    <= ex_reg_we;
                                wb_dst   <= ex_dst;
                                wb_data  <= ex_alu_result;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (dm_rdy) begin
                        wb_valid <= 1'b1;
                        wb_we    <= dm_re & pendWe;
                        wb_dst   <= pendDst;
                        wb_data  <= dm_re ? dm_rdata : dm_addr;
                        dm_re    <= 1'b0;
                        dm_we    <= 1'b0;
                        state    <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction mix checked against a behavioural flag/condition model.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_alu_result;
    logic        ex_v, ex_z, ex_n;
    logic        ex_set_flags;
    logic [15:0] ex_branch_target;
    logic        ex_branch;
    logic [2:0]  ex_cond;
    logic        ex_mem_rd, ex_mem_wr;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_dst;
    logic        ex_reg_we;
    logic        stall, flush;
    logic [15:0] pc_redirect;
    logic [15:0] dm_addr, dm_wdata;
    logic        dm_re, dm_we;
    logic [15:0] dm_rdata;
    logic        dm_rdy;
    logic        wb_valid, wb_we;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data;

    int tests  = 0;
    int failed = 0;

    // Architectural flag model
    bit mV, mZ, mN;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_alu_result    (ex_alu_result),
        .ex_v             (ex_v),
        .ex_z             (ex_z),
        .ex_n             (ex_n),
        .ex_set_flags     (ex_set_flags),
        .ex_branch_target (ex_branch_target),
        .ex_branch        (ex_branch),
        .ex_cond          (ex_cond),
        .ex_mem_rd        (ex_mem_rd),
        .ex_mem_wr        (ex_mem_wr),
        .ex_store_data    (ex_store_data),
        .ex_dst           (ex_dst),
        .ex_reg_we        (ex_reg_we),
        .stall            (stall),
        .flush            (flush),
        .pc_redirect      (pc_redirect),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_re            (dm_re),
        .dm_we            (dm_we),
        .dm_rdata         (dm_rdata),
        .dm_rdy           (dm_rdy),
        .wb_valid         (wb_valid),
        .wb_we            (wb_we),
        .wb_dst           (wb_dst),
        .wb_data          (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit cond_true(input int c, input bit v, input bit z, input bit n);
        case (c)
            0: return z == 0;
            1: return z == 1;
            2: return (z == 0) && (n == 0);
            3: return n == 1;
            4: return (z == 1) || ((z == 0) && (n == 0));
            5: return (n == 1) || (z == 1);
            6: return v == 1;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic junk_inputs(input bit validJunk);
        ex_valid         = validJunk ? 1'($urandom) : 1'b0;
        ex_alu_result    = 16'($urandom);
        {ex_v, ex_z, ex_n} = 3'($urandom);
        ex_set_flags     = 1'($urandom);
        ex_branch_target = 16'($urandom);
        ex_branch        = 1'($urandom);
        ex_cond          = 3'($urandom);
        ex_mem_rd        = 1'($urandom);
        ex_mem_wr        = 1'($urandom);
        ex_store_data    = 16'($urandom);
        ex_dst           = 4'($urandom);
        ex_reg_we        = 1'($urandom);
        dm_rdata         = 16'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_bubble();
        junk_inputs(1'b0);
        dm_rdy = 1'($urandom);
        tick();
        chk("bubble_wb_valid", wb_valid, 0);
        chk("bubble_flush", flush, 0);
        chk("bubble_stall", stall, 0);
    endtask

    task automatic do_alu(input logic [15:0] res, input logic [3:0] dst, input bit we,
                          input bit sf, input bit v, input bit z, input bit n);
        junk_inputs(1'b0);
        ex_valid = 1; ex_branch = 0; ex_mem_rd = 0; ex_mem_wr = 0;
        ex_alu_result = res; ex_dst = dst; ex_reg_we = we;
        ex_set_flags = sf; ex_v = v; ex_z = z; ex_n = n;
        dm_rdy = 1'($urandom);
        tick();
        if (sf) begin mV = v; mZ = z; mN = n; end
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, res);
        chk("alu_wb_dst", wb_dst, dst);
        chk("alu_wb_we", wb_we, we);
        chk("alu_stall", stall, 0);
        chk("alu_flush", flush, 0);
        ex_valid = 0;
    endtask

    task automatic do_branch(input int c, input logic [15:0] target);
        bit exp;
        exp = cond_true(c, mV, mZ, mN);
        junk_inputs(1'b0);
        ex_valid = 1; ex_branch = 1; ex_cond = 3'(c); ex_branch_target = target;
        tick();
        chk($sformatf("br_flush_c%0d_f%0d%0d%0d", c, mV, mZ, mN), flush, exp);
        if (exp) chk("br_redirect", pc_redirect, target);
        chk("br_wb_valid", wb_valid, 1);
        chk("br_wb_we", wb_we, 0);
        chk("br_stall", stall, 0);
        chk("br_no_mem", {dm_re, dm_we}, 0);
        ex_valid = 0;
    endtask

    task automatic do_mem(input bit isLoad, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [3:0] dst, input bit we, input int waits,
                          input logic [15:0] rdata);
        bit sf, v, z, n;
        junk_inputs(1'b0);
        sf = 1'($urandom); {v, z, n} = 3'($urandom);
        ex_valid = 1; ex_branch = 0;
        ex_mem_rd = isLoad;
        ex_mem_wr = isLoad ? 1'($urandom) : 1'b1;
        ex_alu_result = addr; ex_store_data = wdata; ex_dst = dst; ex_reg_we = we;
        ex_set_flags = sf; ex_v = v; ex_z = z; ex_n = n;
        tick();
        if (sf) begin mV = v; mZ = z; mN = n; end
        for (int i = 0; i <= waits; i++) begin
            chk("mem_stall", stall, 1);
            chk("mem_dm_re", dm_re, isLoad);
            chk("mem_dm_we", dm_we, !isLoad);
            chk("mem_dm_addr", dm_addr, addr);
            if (!isLoad) chk("mem_dm_wdata", dm_wdata, wdata);
            chk("mem_wb_idle", wb_valid, 0);
            junk_inputs(1'b1);
            dm_rdy = (i == waits);
            if (i == waits) dm_rdata = rdata;
            tick();
        end
        chk("mem_done_wb_valid", wb_valid, 1);
        chk("mem_done_wb_we", wb_we, isLoad && we);
        chk("mem_done_wb_dst", wb_dst, dst);
        if (isLoad) chk("mem_done_wb_data", wb_data, rdata);
        chk("mem_done_stall", stall, 0);
        chk("mem_done_req", {dm_re, dm_we}, 0);
        ex_valid = 0;
        dm_rdy = 0;
    endtask

    initial begin
        junk_inputs(1'b0);
        dm_rdy = 0;
        rst = 1;
        mV = 0; mZ = 0; mN = 0;
        #12;
        chk("rst_outputs", {stall, flush, pc_redirect, dm_re, dm_we, wb_valid, wb_we}, 0);
        chk("rst_addr_data", {dm_addr, dm_wdata}, 0);
        chk("rst_wb", {wb_dst, wb_data}, 0);
        @(negedge clk);
        rst = 0;
        tick();

        // Reset asserted while a load is pending
        junk_inputs(1'b0);
        ex_valid = 1; ex_branch = 0; ex_mem_rd = 1; ex_set_flags = 0;
        ex_alu_result = 16'h0040;
        tick();
        chk("pre_rst_dm_re", dm_re, 1);
        ex_valid = 0;
        dm_rdy = 1;
        #2 rst = 1;
        #1;
        chk("async_rst_dm_re", dm_re, 0);
        chk("async_rst_stall", stall, 0);
        tick();
        rst = 0;
        dm_rdy = 0;
        tick();
        chk("post_rst_wb_valid", wb_valid, 0);
        chk("post_rst_stall", stall, 0);
        mV = 0; mZ = 0; mN = 0;

        // Flags reset to zero: NE taken, EQ not
        do_branch(1, 16'h0100);
        do_branch(0, 16'h0104);

        do_alu(16'h1234, 4'd5, 1, 0, 0, 0, 0);
        do_bubble();

        do_mem(1, 16'h0040, 16'h0000, 4'd3, 1, 3, 16'hBEEF);
        do_mem(0, 16'h0010, 16'h00FF, 4'd7, 1, 0, 16'h0000);

        do_alu(16'h0000, 4'd1, 1, 1, 0, 1, 0);
        do_branch(1, 16'h0200);
        do_bubble();
        do_alu(16'h0000, 4'd1, 1, 1, 0, 1, 0);
        do_branch(0, 16'h0200);

        for (int f = 0; f < 8; f++) begin
            do_alu(16'($urandom), 4'($urandom), 1'($urandom), 1, f[2], f[1], f[0]);
            for (int c = 0; c < 8; c++) do_branch(c, 16'($urandom));
        end

        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 4))
                0: do_bubble();
                1: do_alu(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom));
                2: do_branch(int'($urandom_range(0, 7)), 16'($urandom));
                3: do_mem(1, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
                          int'($urandom_range(0, 4)), 16'($urandom));
                default: do_mem(0, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
                                int'($urandom_range(0, 4)), 16'($urandom));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
